// File: rtl/axi4_lite_pkg.sv
`timescale 1ns/1ps
// Shared AXI4-Lite constants, FSM state types and the address decoder used by both channels.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_EXOKAY  = 2'b01;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_DECERR  = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } w_state_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_VALID = 1'b1
    } r_state_t;

    typedef struct packed {
        logic [31:0] idx;
        logic [1:0]  resp;
    } axil_dec_t;

    // Offset wraps modulo 2^32, so addresses below the base land far out of range.
    // Misalignment is reported ahead of the range check.
    function automatic axil_dec_t axil_decode(input logic [31:0] addr,
                                              input logic [31:0] base,
                                              input int unsigned num_regs);
        logic [31:0] off;
        axil_dec_t   d;
        off    = addr - base;
        d.idx  = {2'b00, off[31:2]};
        d.resp = RESP_OKAY;
        if (off[1:0] != 2'b00) begin
            d.idx  = '0;
            d.resp = RESP_SLVERR;
        end else if (off >= (num_regs << 2)) begin
            d.idx  = '0;
            d.resp = RESP_DECERR;
        end
        return d;
    endfunction

endpackage

// File: rtl/axil_reg_bank.sv
`timescale 1ns/1ps
// Register storage: NUM_REGS x 32 with byte-strobe writes, combinational read mux, write pulses.
// Latency: write lands at the commit edge; reg_wr_o pulses for the following cycle; read is combinational.
// Backpressure: none, always accepts a write when wr_en_i is high.
module axil_reg_bank
    import axi4_lite_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [IDX_W-1:0]         wr_idx_i,
    input  logic [31:0]              wr_data_i,
    input  logic [3:0]               wr_strb_i,
    input  logic [IDX_W-1:0]         rd_idx_i,
    output logic [31:0]              rd_data_o,
    output logic [32*NUM_REGS-1:0]   reg_q_o,
    output logic [NUM_REGS-1:0]      reg_wr_o
);

    logic [31:0]         regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] reg_wr_q;

    // Storage update with per-byte strobes and a one-cycle pulse for the written register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            reg_wr_q <= '0;
        end else begin
            reg_wr_q <= '0;
            if (wr_en_i) begin
                reg_wr_q[wr_idx_i] <= 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (wr_strb_i[b]) begin
                        regs_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                    end
                end
            end
        end
    end

    assign rd_data_o = regs_q[rd_idx_i];
    assign reg_wr_o  = reg_wr_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign reg_q_o[32*i +: 32] = regs_q[i];
    end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
`timescale 1ns/1ps
// AXI4-Lite slave terminating CPU accesses onto a bank of 32-bit control registers.
// Latency: write commits at the later of the AW/W handshakes with BVALID after that edge; RVALID one edge after AR.
// Backpressure: one outstanding transaction per channel; READYs depend on state only and drop while B/R are pending.
module axi4_lite_slave_regs
    import axi4_lite_pkg::*;
#(
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              S_AXI_AWADDR,
    input  logic [2:0]               S_AXI_AWPROT,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [31:0]              S_AXI_WDATA,
    input  logic [3:0]               S_AXI_WSTRB,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    input  logic [31:0]              S_AXI_ARADDR,
    input  logic [2:0]               S_AXI_ARPROT,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    output logic [31:0]              S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    output logic [32*NUM_REGS-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      reg_wr
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    w_state_t    wstate_q;
    r_state_t    rstate_q;
    logic [31:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        commit;
    logic [31:0] c_addr;
    logic [31:0] c_data;
    logic [3:0]  c_strb;
    axil_dec_t   wr_dec;
    axil_dec_t   rd_dec;
    logic        bank_wr_en;
    logic [31:0] bank_rd_data;

    // READYs come from state alone; rst masks them so they read 0 throughout reset
    // and 1 in the very first cycle after release.
    assign S_AXI_AWREADY = ~rst & ((wstate_q == W_IDLE) | (wstate_q == W_DATA));
    assign S_AXI_WREADY  = ~rst & ((wstate_q == W_IDLE) | (wstate_q == W_ADDR));
    assign S_AXI_ARREADY = ~rst & (rstate_q == R_IDLE);

    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    // Pick the address/data pair that completes a write this cycle, live or held.
    always_comb begin
        commit = 1'b0;
        c_addr = S_AXI_AWADDR;
        c_data = S_AXI_WDATA;
        c_strb = S_AXI_WSTRB;
        case (wstate_q)
            W_IDLE: commit = aw_hs & w_hs;
            W_ADDR: begin
                commit = w_hs;
                c_addr = aw_addr_q;
            end
            W_DATA: begin
                commit = aw_hs;
                c_data = w_data_q;
                c_strb = w_strb_q;
            end
            default: commit = 1'b0;
        endcase
    end

    assign wr_dec     = axil_decode(c_addr, BASE_ADDR, NUM_REGS);
    assign rd_dec     = axil_decode(S_AXI_ARADDR, BASE_ADDR, NUM_REGS);
    assign bank_wr_en = commit & (wr_dec.resp == RESP_OKAY);

    axil_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (bank_wr_en),
        .wr_idx_i  (wr_dec.idx[IDX_W-1:0]),
        .wr_data_i (c_data),
        .wr_strb_i (c_strb),
        .rd_idx_i  (rd_dec.idx[IDX_W-1:0]),
        .rd_data_o (bank_rd_data),
        .reg_q_o   (reg_q),
        .reg_wr_o  (reg_wr)
    );

    // Write channel FSM: hold whichever of AW/W arrives first, commit on the second, then wait for BREADY.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else if (commit) begin
            wstate_q <= W_RESP;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_dec.resp;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q <= S_AXI_AWADDR;
                        wstate_q  <= W_ADDR;
                    end else if (w_hs) begin
                        w_data_q <= S_AXI_WDATA;
                        w_strb_q <= S_AXI_WSTRB;
                        wstate_q <= W_DATA;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q <= 1'b0;
                        wstate_q <= W_IDLE;
                    end
                end
                default: wstate_q <= wstate_q;
            endcase
        end
    end

    // Read channel FSM: capture data at the AR handshake (pre-write value on a same-edge write), hold until RREADY.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q <= R_IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rstate_q <= R_VALID;
                        rvalid_q <= 1'b1;
                        rresp_q  <= rd_dec.resp;
                        rdata_q  <= (rd_dec.resp == RESP_OKAY) ? bank_rd_data : '0;
                    end
                end
                R_VALID: begin
                    if (S_AXI_RREADY) begin
                        rstate_q <= R_IDLE;
                        rvalid_q <= 1'b0;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = rresp_q;

    // PROT is ignored and only the low index bits select a register.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           wr_dec.idx[31:IDX_W], rd_dec.idx[31:IDX_W]};

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
`timescale 1ns/1ps
// Bench for axi4_lite_slave_regs: directed scenarios plus randomized traffic against an array model.
// Latency: n/a.
// Backpressure: exercises delayed BREADY/RREADY and split AW/W arrival.
module tb_axi4_lite_slave_regs;

    localparam int          NR   = 16;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       S_AXI_AWADDR;
    logic [2:0]        S_AXI_AWPROT;
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [31:0]       S_AXI_WDATA;
    logic [3:0]        S_AXI_WSTRB;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic [31:0]       S_AXI_ARADDR;
    logic [2:0]        S_AXI_ARPROT;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [31:0]       S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;
    logic [32*NR-1:0]  reg_q;
    logic [NR-1:0]     reg_wr;

    axi4_lite_slave_regs #(.NUM_REGS(NR), .BASE_ADDR(BASE)) dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .reg_q         (reg_q),
        .reg_wr        (reg_wr)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] mdl [NR];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected response from plain offset arithmetic.
    function automatic logic [1:0] exp_resp(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        if (off % 4 != 0) return 2'b10;
        if (off / 4 >= NR) return 2'b11;
        return 2'b00;
    endfunction

    function automatic int exp_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return int'(off / 4);
    endfunction

    task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
        for (int k = 0; k < 4; k++)
            if (strb[k]) mdl[idx][8*k +: 8] = data[8*k +: 8];
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < NR; i++) check(tag, reg_q[32*i +: 32], mdl[i]);
    endtask

    task automatic b_phase(input logic [1:0] er, input int b_dly);
        S_AXI_BREADY = 1'b0;
        for (int i = 0; i < b_dly; i++) begin
            step();
            check("b_hold_vld", S_AXI_BVALID, 1);
            check("b_hold_resp", S_AXI_BRESP, er);
            check("b_hold_awready", S_AXI_AWREADY, 0);
            check("b_hold_wr_pulse_off", reg_wr, 0);
        end
        S_AXI_BREADY = 1'b1;
        step();
        S_AXI_BREADY = 1'b0;
        check("b_done_vld", S_AXI_BVALID, 0);
        check("b_done_awready", S_AXI_AWREADY, 1);
        check("b_done_wready", S_AXI_WREADY, 1);
        check("b_done_wr_pulse_off", reg_wr, 0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        bit          aw_done, w_done, aw_fire, w_fire;
        int          cyc, idx;
        logic [1:0]  er;
        logic [NR-1:0] ewr;
        aw_done = 0; w_done = 0; cyc = 0;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
            S_AXI_WVALID  = !w_done && cyc >= w_dly;
            aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
            w_fire  = S_AXI_WVALID && S_AXI_WREADY;
            step();
            aw_done |= aw_fire; w_done |= w_fire; cyc++;
            if (aw_done && !w_done) begin
                check("aw_held_awready", S_AXI_AWREADY, 0);
                check("aw_held_wready", S_AXI_WREADY, 1);
                check("aw_held_bvalid", S_AXI_BVALID, 0);
            end
            if (w_done && !aw_done) begin
                check("w_held_awready", S_AXI_AWREADY, 1);
                check("w_held_wready", S_AXI_WREADY, 0);
                check("w_held_bvalid", S_AXI_BVALID, 0);
            end
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        if (!(aw_done && w_done)) begin
            check("wr_handshake_timeout", aw_done && w_done, 1);
            return;
        end
        er  = exp_resp(addr);
        ewr = '0;
        check("wr_bvalid", S_AXI_BVALID, 1);
        check("wr_bresp", S_AXI_BRESP, er);
        if (er == 2'b00) begin
            idx = exp_idx(addr);
            model_write(idx, data, strb);
            ewr[idx] = 1'b1;
            check("wr_reg_value", reg_q[32*idx +: 32], mdl[idx]);
        end
        check("wr_pulse", reg_wr, ewr);
        b_phase(er, b_dly);
    endtask

    task automatic do_read(input logic [31:0] addr, input int r_dly);
        logic [1:0]  er;
        logic [31:0] ed;
        int          cyc;
        bit          fired;
        er = exp_resp(addr);
        ed = '0;
        if (er == 2'b00) ed = mdl[exp_idx(addr)];
        cyc = 0; fired = 0;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        while (!fired && cyc < 40) begin
            fired = S_AXI_ARREADY;
            step();
            cyc++;
        end
        S_AXI_ARVALID = 1'b0;
        if (!fired) begin
            check("rd_handshake_timeout", fired, 1);
            return;
        end
        check("rd_rvalid", S_AXI_RVALID, 1);
        check("rd_rdata", S_AXI_RDATA, ed);
        check("rd_rresp", S_AXI_RRESP, er);
        check("rd_arready_busy", S_AXI_ARREADY, 0);
        S_AXI_RREADY = 1'b0;
        for (int i = 0; i < r_dly; i++) begin
            step();
            check("rd_hold_vld", S_AXI_RVALID, 1);
            check("rd_hold_data", S_AXI_RDATA, ed);
            check("rd_hold_resp", S_AXI_RRESP, er);
        end
        S_AXI_RREADY = 1'b1;
        step();
        S_AXI_RREADY = 1'b0;
        check("rd_done_vld", S_AXI_RVALID, 0);
        check("rd_done_arready", S_AXI_ARREADY, 1);
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 7) return BASE + 32'(4 * $urandom_range(0, NR - 1));
        if (sel == 7) return BASE + 32'(4 * $urandom_range(0, NR - 1) + $urandom_range(1, 3));
        return BASE + 32'(4 * NR + 4 * $urandom_range(0, 1000));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        rst = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0;  S_AXI_WSTRB = '0;  S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_awready", S_AXI_AWREADY, 0);
        check("rst_wready", S_AXI_WREADY, 0);
        check("rst_arready", S_AXI_ARREADY, 0);
        check("rst_bvalid", S_AXI_BVALID, 0);
        check("rst_rvalid", S_AXI_RVALID, 0);
        check("rst_reg_wr", reg_wr, 0);
        check_bank("rst_bank");
        rst = 1'b0;
        #1;
        check("post_rst_awready", S_AXI_AWREADY, 1);
        check("post_rst_wready", S_AXI_WREADY, 1);
        check("post_rst_arready", S_AXI_ARREADY, 1);

        // Simultaneous AW/W, then W two cycles ahead of AW with delayed BREADY
        do_write(32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        do_write(32'h4, 32'h1234_5678, 4'b0011, 2, 0, 5);
        check("partial_strobe_reg1", reg_q[63:32], 32'hDEAD_5678);

        // Read back with RREADY held off
        do_read(32'h4, 3);

        // Error decode
        do_write(32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, 1);
        check_bank("decerr_no_change");
        do_write(32'h6, 32'hFFFF_FFFF, 4'hF, 1, 0, 0);
        do_read(32'h6, 0);
        do_read(32'hFFFF_FFFC, 1);
        do_write(32'h8, 32'h0, 4'h0, 0, 0, 0);

        // Same-edge read and write of register 2
        do_write(32'h8, 32'hAAAA_AAAA, 4'hF, 0, 0, 0);
        S_AXI_AWADDR = 32'h8; S_AXI_AWVALID = 1'b1;
        check("coll_awready", S_AXI_AWREADY, 1);
        step();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = 32'h5555_5555; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 32'h8; S_AXI_ARVALID = 1'b1;
        check("coll_wready", S_AXI_WREADY, 1);
        check("coll_arready", S_AXI_ARREADY, 1);
        step();
        S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        check("coll_rvalid", S_AXI_RVALID, 1);
        check("coll_rdata_old", S_AXI_RDATA, mdl[2]);
        check("coll_bvalid", S_AXI_BVALID, 1);
        model_write(2, 32'h5555_5555, 4'hF);
        check("coll_reg2_new", reg_q[95:64], mdl[2]);
        check("coll_pulse", reg_wr, 16'h0004);
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        step();
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        check("coll_b_done", S_AXI_BVALID, 0);
        check("coll_r_done", S_AXI_RVALID, 0);
        do_read(32'h8, 0);

        // Reset while AW is held and a read response is pending
        S_AXI_AWADDR = 32'hC; S_AXI_AWVALID = 1'b1;
        S_AXI_ARADDR = 32'h4; S_AXI_ARVALID = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        check("mid_w_addr_awready", S_AXI_AWREADY, 0);
        check("mid_rvalid_pending", S_AXI_RVALID, 1);
        S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        rst = 1'b1;
        #1;
        check("mid_rst_wready", S_AXI_WREADY, 0);
        check("mid_rst_arready", S_AXI_ARREADY, 0);
        step();
        step();
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        check("mid_rst_bvalid", S_AXI_BVALID, 0);
        check("mid_rst_rvalid", S_AXI_RVALID, 0);
        check("mid_rst_rdata", S_AXI_RDATA, 0);
        check("mid_rst_reg_wr", reg_wr, 0);
        check_bank("mid_rst_bank");
        rst = 1'b0;
        #1;
        check("late_w_wready", S_AXI_WREADY, 1);
        step();
        S_AXI_WVALID = 1'b0;
        check("late_w_awready", S_AXI_AWREADY, 1);
        check("late_w_wready_off", S_AXI_WREADY, 0);
        check("late_w_no_bvalid", S_AXI_BVALID, 0);
        check("late_w_no_pulse", reg_wr, 0);
        S_AXI_AWADDR = 32'h10; S_AXI_AWVALID = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0;
        model_write(4, 32'h0BAD_F00D, 4'hF);
        check("late_w_bvalid", S_AXI_BVALID, 1);
        check("late_w_bresp", S_AXI_BRESP, 0);
        check("late_w_pulse", reg_wr, 16'h0010);
        check_bank("late_w_bank");
        b_phase(2'b00, 0);

        // Randomized traffic
        for (int t = 0; t < 120; t++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(rand_addr(), $urandom_range(0, 2));
        end
        check_bank("final_bank");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
